// File: rtl/ascii_to_bcd_receiver.sv
// Parses ASCII decimal digits (MSD first, TERM_CHAR-terminated) into packed BCD; result 1 cycle after TERM.
// Backpressure: asciiReady drops while a result waits in HOLD for bcdReady. Option: ASCII2BCD_SPACE_SKIP_EN.
// Overflow or illegal characters discard the field and yield an error result with bcdOutput=0.
module ascii_to_bcd_receiver #(
    parameter int          BCD_NUMBER_LENGTH = 3,
    parameter logic [7:0]  TERM_CHAR         = 8'h0D,
    localparam int         CW                = $clog2(BCD_NUMBER_LENGTH + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             asciiValid,
    input  logic [7:0]                       asciiData,
    output logic                             asciiReady,
    output logic [4*BCD_NUMBER_LENGTH-1:0]   bcdOutput,
    output logic                             bcdValid,
    input  logic                             bcdReady,
    output logic                             bcdError,
    output logic [CW-1:0]                    digitCount
);
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

    state_t                           state;
    logic [4*BCD_NUMBER_LENGTH-1:0]   shreg;
    logic                             accept;
    logic                             is_digit;
    logic                             is_term;
    logic                             is_space;

    assign accept   = asciiValid && asciiReady;
    assign is_digit = (asciiData >= 8'h30) && (asciiData <= 8'h39);
    assign is_term  = (asciiData == TERM_CHAR);
`ifdef ASCII2BCD_SPACE_SKIP_EN
    assign is_space = (asciiData == 8'h20);
`else
    assign is_space = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            digitCount <= '0;
            bcdOutput  <= '0;
            bcdValid   <= 1'b0;
            bcdError   <= 1'b0;
            asciiReady <= 1'b0;
        end else begin
            // Ready mirrors "not in HOLD"; the register only lags reset release by one edge.
            if (state != HOLD)
                asciiReady <= 1'b1;
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        if (is_digit) begin
                            if (digitCount == CW'(BCD_NUMBER_LENGTH)) begin
                                state <= DRAIN;
                            end else begin
                                shreg      <= {shreg[4*BCD_NUMBER_LENGTH-5:0], asciiData[3:0]};
                                digitCount <= digitCount + 1'b1;
                                state      <= ACCUM;
                            end
                        end else if (is_term) begin
                            // Empty field in IDLE produces nothing.
                            if (state == ACCUM) begin
                                bcdOutput  <= shreg;
                                bcdValid   <= 1'b1;
                                bcdError   <= 1'b0;
                                asciiReady <= 1'b0;
                                state      <= HOLD;
                            end
                        end else if (!is_space) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (accept && is_term) begin
                        bcdOutput  <= '0;
                        bcdValid   <= 1'b1;
                        bcdError   <= 1'b1;
                        asciiReady <= 1'b0;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (bcdReady) begin
                        bcdValid   <= 1'b0;
                        shreg      <= '0;
                        digitCount <= '0;
                        asciiReady <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
